// File: rtl/load_align.sv
// Load return-path aligner: tracks in-flight loads against a synchronous-read data
// memory, then extracts and sign/zero-extends the addressed byte, halfword or word.
module load_align #(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic [31:0] req_addr_i,
    input  logic [2:0]  req_funct3_i,
    input  logic        stall_i,
    input  logic [31:0] mem_rdata_i,
    output logic        load_valid_o,
    output logic [31:0] load_data_o,
    output logic        load_err_o
);
    localparam logic [2:0] FNC_LB  = 3'b000;
    localparam logic [2:0] FNC_LH  = 3'b001;
    localparam logic [2:0] FNC_LW  = 3'b010;
    localparam logic [2:0] FNC_LBU = 3'b100;
    localparam logic [2:0] FNC_LHU = 3'b101;
    localparam int         F       = RD_LATENCY - 1;

    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [RD_LATENCY-1:0] err_q, err_d;
    logic [1:0]            off_q [RD_LATENCY];
    logic [1:0]            off_d [RD_LATENCY];
    logic [2:0]            f3_q  [RD_LATENCY];
    logic [2:0]            f3_d  [RD_LATENCY];
    logic                  hold_vld_q, hold_vld_d;
    logic [31:0]           hold_q, hold_d;
    logic                  err_calc;
    logic [31:0]           src;
    logic [7:0]            byte_w;
    logic [15:0]           half_w;
    logic                  unused_addr;

    assign unused_addr = ^req_addr_i[31:2];

    always_comb begin
        case (req_funct3_i)
            FNC_LB, FNC_LBU: err_calc = 1'b0;
            FNC_LH, FNC_LHU: err_calc = req_addr_i[0];
            FNC_LW:          err_calc = |req_addr_i[1:0];
            default:         err_calc = 1'b1;
        endcase
    end

    // The final stage's word is captured on the first stalled cycle so memory may move on.
    always_comb begin
        vld_d      = vld_q;
        err_d      = err_q;
        off_d      = off_q;
        f3_d       = f3_q;
        hold_vld_d = hold_vld_q;
        hold_d     = hold_q;
        if (!stall_i) begin
            vld_d[0] = req_valid_i;
            err_d[0] = err_calc;
            off_d[0] = req_addr_i[1:0];
            f3_d[0]  = req_funct3_i;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
                err_d[i] = err_q[i-1];
                off_d[i] = off_q[i-1];
                f3_d[i]  = f3_q[i-1];
            end
            hold_vld_d = 1'b0;
        end else if (vld_q[F] && !hold_vld_q) begin
            hold_vld_d = 1'b1;
            hold_d     = mem_rdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q      <= '0;
            err_q      <= '0;
            hold_vld_q <= 1'b0;
            hold_q     <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                off_q[i] <= '0;
                f3_q[i]  <= '0;
            end
        end else begin
            vld_q      <= vld_d;
            err_q      <= err_d;
            off_q      <= off_d;
            f3_q       <= f3_d;
            hold_vld_q <= hold_vld_d;
            hold_q     <= hold_d;
        end
    end

    assign src    = hold_vld_q ? hold_q : mem_rdata_i;
    assign byte_w = 8'(src >> {off_q[F], 3'b000});
    assign half_w = 16'(src >> {off_q[F][1], 4'b0000});

    // Gating with rst_i keeps a load that reaches the last stage during reset from showing.
    always_comb begin
        load_valid_o = vld_q[F] & ~rst_i;
        load_data_o  = '0;
        load_err_o   = 1'b0;
        if (load_valid_o) begin
            if (err_q[F]) begin
                load_err_o = 1'b1;
            end else begin
                case (f3_q[F])
                    FNC_LB:  load_data_o = {{24{byte_w[7]}}, byte_w};
                    FNC_LBU: load_data_o = {24'h0, byte_w};
                    FNC_LH:  load_data_o = {{16{half_w[15]}}, half_w};
                    FNC_LHU: load_data_o = {16'h0, half_w};
                    default: load_data_o = src;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_load_align.sv
// Bench for load_align: two instances (latency 1 and 2) share request/stall inputs and
// each gets its own memory return path from a delay-line memory model in the bench.
module tb_load_align;
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

    logic        clk = 1'b0;
    logic        rst, req_valid, stall;
    logic [31:0] req_addr;
    logic [2:0]  req_f3;
    logic [31:0] md    [2];
    logic        act_v [2];
    logic [31:0] act_d [2];
    logic        act_e [2];

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mem [16];
    logic [31:0] junk;
    logic        m_vld  [2][4];
    logic [31:0] m_addr [2][4];
    logic [2:0]  m_f3   [2][4];
    logic        hold   [2];
    logic        ev [2];
    logic [31:0] ed [2];
    logic        ee [2];

    always #5 clk = ~clk;

    load_align #(.RD_LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_addr_i(req_addr),
        .req_funct3_i(req_f3), .stall_i(stall), .mem_rdata_i(md[0]),
        .load_valid_o(act_v[0]), .load_data_o(act_d[0]), .load_err_o(act_e[0])
    );

    load_align #(.RD_LATENCY(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_addr_i(req_addr),
        .req_funct3_i(req_f3), .stall_i(stall), .mem_rdata_i(md[1]),
        .load_valid_o(act_v[1]), .load_data_o(act_d[1]), .load_err_o(act_e[1])
    );

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    // Returns {err, data} for a load of word w at byte offset off.
    function automatic logic [32:0] ref_load(input logic [2:0] f, input logic [1:0] off,
                                             input logic [31:0] w);
        int unsigned v;
        case (f)
            LB, LBU: begin
                v = (w >> (8 * int'(off))) & 32'hFF;
                if (f == LB && v >= 128) v = v + 32'hFFFF_FF00;
                return {1'b0, v};
            end
            LH, LHU: begin
                if (off[0]) return {1'b1, 32'h0};
                v = (w >> (16 * int'(off[1]))) & 32'hFFFF;
                if (f == LH && v >= 32768) v = v + 32'hFFFF_0000;
                return {1'b0, v};
            end
            LW: begin
                if (off != 2'b00) return {1'b1, 32'h0};
                return {1'b0, w};
            end
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    // Applies this cycle's inputs (called at negedge) and computes memory output and expectations.
    task automatic drive(input logic r, input logic rv, input logic [31:0] a,
                         input logic [2:0] f, input logic st);
        int          l;
        logic [31:0] w;
        logic [32:0] res;
        rst = r; req_valid = rv; req_addr = a; req_f3 = f; stall = st;
        for (int k = 0; k < 2; k++) begin
            l = lat(k);
            if (m_vld[k][l-1]) begin
                w     = mem[m_addr[k][l-1][5:2]];
                res   = ref_load(m_f3[k][l-1], m_addr[k][l-1][1:0], w);
                md[k] = hold[k] ? junk : w;
                ev[k] = !r;
                ed[k] = r ? 32'h0 : res[31:0];
                ee[k] = !r && res[32];
            end else begin
                md[k] = junk;
                ev[k] = 1'b0;
                ed[k] = 32'h0;
                ee[k] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic advance();
        int l;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            l = lat(k);
            if (rst) begin
                for (int i = 0; i < 4; i++) m_vld[k][i] = 1'b0;
                hold[k] = 1'b0;
            end else if (stall) begin
                if (m_vld[k][l-1]) hold[k] = 1'b1;
            end else begin
                hold[k] = 1'b0;
                for (int i = l - 1; i > 0; i--) begin
                    m_vld[k][i]  = m_vld[k][i-1];
                    m_addr[k][i] = m_addr[k][i-1];
                    m_f3[k][i]   = m_f3[k][i-1];
                end
                m_vld[k][0]  = req_valid;
                m_addr[k][0] = req_addr;
                m_f3[k][0]   = req_f3;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            drive(c < 2, 1'b1, 32'h0, LW, 1'b0);
            if (c == 2) drive(1'b0, 1'b0, 32'h0, LW, 1'b0);
            for (int k = 0; k < 2; k++) begin
                total++;
                if ({act_v[k], act_d[k], act_e[k]} !== 34'h0) begin
                    bad++;
                    $display("FAIL reset_dut%0d cyc=%0d got=%h exp=0", k + 1, c,
                             {act_v[k], act_d[k], act_e[k]});
                end
            end
            advance();
        end
    endtask

    task automatic test_lb_sign();
        logic [33:0] e1 [3];
        logic [33:0] e2 [3];
        mem[0] = 32'h80FF_1234;
        e1 = '{34'h0, {1'b1, 32'hFFFF_FF80, 1'b0}, 34'h0};
        e2 = '{34'h0, 34'h0, {1'b1, 32'hFFFF_FF80, 1'b0}};
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, c == 0, 32'h103, LB, 1'b0);
            total++;
            if ({act_v[0], act_d[0], act_e[0]} !== e1[c]) begin
                bad++;
                $display("FAIL lb_dut1 cyc=%0d got=%h exp=%h", c, {act_v[0], act_d[0], act_e[0]}, e1[c]);
            end
            total++;
            if ({act_v[1], act_d[1], act_e[1]} !== e2[c]) begin
                bad++;
                $display("FAIL lb_dut2 cyc=%0d got=%h exp=%h", c, {act_v[1], act_d[1], act_e[1]}, e2[c]);
            end
            advance();
        end
    endtask

    task automatic test_half();
        logic [33:0] e1 [4];
        logic [33:0] e2 [4];
        mem[0] = 32'h8001_0000;
        e1 = '{34'h0, {1'b1, 32'h0000_8001, 1'b0}, {1'b1, 32'hFFFF_8001, 1'b0}, 34'h0};
        e2 = '{34'h0, 34'h0, {1'b1, 32'h0000_8001, 1'b0}, {1'b1, 32'hFFFF_8001, 1'b0}};
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, c < 2, 32'h102, (c == 0) ? LHU : LH, 1'b0);
            total++;
            if ({act_v[0], act_d[0], act_e[0]} !== e1[c]) begin
                bad++;
                $display("FAIL half_dut1 cyc=%0d got=%h exp=%h", c, {act_v[0], act_d[0], act_e[0]}, e1[c]);
            end
            total++;
            if ({act_v[1], act_d[1], act_e[1]} !== e2[c]) begin
                bad++;
                $display("FAIL half_dut2 cyc=%0d got=%h exp=%h", c, {act_v[1], act_d[1], act_e[1]}, e2[c]);
            end
            advance();
        end
    endtask

    task automatic test_err();
        logic [33:0] e1 [4];
        logic [33:0] e2 [4];
        e1 = '{34'h0, 34'h1, 34'h1, 34'h0};
        e2 = '{34'h0, 34'h0, 34'h1, 34'h1};
        e1[1][33] = 1'b1; e1[2][33] = 1'b1;
        e2[2][33] = 1'b1; e2[3][33] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, c < 2, (c == 0) ? 32'h101 : 32'h100, (c == 0) ? LW : 3'b011, 1'b0);
            total++;
            if ({act_v[0], act_d[0], act_e[0]} !== e1[c]) begin
                bad++;
                $display("FAIL err_dut1 cyc=%0d got=%h exp=%h", c, {act_v[0], act_d[0], act_e[0]}, e1[c]);
            end
            total++;
            if ({act_v[1], act_d[1], act_e[1]} !== e2[c]) begin
                bad++;
                $display("FAIL err_dut2 cyc=%0d got=%h exp=%h", c, {act_v[1], act_d[1], act_e[1]}, e2[c]);
            end
            advance();
        end
    endtask

    task automatic test_stall_hold();
        logic [33:0] e1 [7];
        logic [33:0] e2 [7];
        logic        st [7];
        int          commits [2];
        logic [33:0] wv;
        mem[1] = 32'h1357_9BDF;
        wv = {1'b1, 32'h1357_9BDF, 1'b0};
        e1 = '{34'h0, wv, wv, wv, wv, 34'h0, 34'h0};
        e2 = '{34'h0, 34'h0, 34'h0, 34'h0, 34'h0, wv, 34'h0};
        st = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        commits = '{0, 0};
        for (int c = 0; c < 7; c++) begin
            junk = (c >= 2) ? 32'hDEAD_BEEF : 32'h0BAD_0001;
            drive(1'b0, c == 0, 32'h104, LW, st[c]);
            for (int k = 0; k < 2; k++)
                if (act_v[k] && !st[c]) commits[k]++;
            total++;
            if ({act_v[0], act_d[0], act_e[0]} !== e1[c]) begin
                bad++;
                $display("FAIL hold_dut1 cyc=%0d got=%h exp=%h", c, {act_v[0], act_d[0], act_e[0]}, e1[c]);
            end
            total++;
            if ({act_v[1], act_d[1], act_e[1]} !== e2[c]) begin
                bad++;
                $display("FAIL hold_dut2 cyc=%0d got=%h exp=%h", c, {act_v[1], act_d[1], act_e[1]}, e2[c]);
            end
            advance();
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (commits[k] != 1) begin
                bad++;
                $display("FAIL hold_commits_dut%0d got=%0d exp=1", k + 1, commits[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] val [4];
        logic [33:0] e1, e2;
        mem[0] = 32'h8C7F_01A5;
        val = '{32'hFFFF_FFA5, 32'h0000_0001, 32'h0000_007F, 32'hFFFF_FF8C};
        for (int c = 0; c < 7; c++) begin
            drive(1'b0, c < 4, 32'h200 + 32'(c), LB, 1'b0);
            e1 = (c >= 1 && c <= 4) ? {1'b1, val[c-1], 1'b0} : 34'h0;
            e2 = (c >= 2 && c <= 5) ? {1'b1, val[c-2], 1'b0} : 34'h0;
            total++;
            if ({act_v[0], act_d[0], act_e[0]} !== e1) begin
                bad++;
                $display("FAIL b2b_dut1 cyc=%0d got=%h exp=%h", c, {act_v[0], act_d[0], act_e[0]}, e1);
            end
            total++;
            if ({act_v[1], act_d[1], act_e[1]} !== e2) begin
                bad++;
                $display("FAIL b2b_dut2 cyc=%0d got=%h exp=%h", c, {act_v[1], act_d[1], act_e[1]}, e2);
            end
            advance();
        end
    endtask

    task automatic test_rst_midflight();
        logic [33:0] e1, e2;
        logic        rv;
        logic [31:0] a;
        for (int c = 0; c < 9; c++) begin
            rv = (c < 2) || (c == 5);
            a  = (c == 5) ? 32'h8 : 32'(c * 4);
            drive(c == 2, rv, a, LW, 1'b0);
            e1 = (c == 1) ? {1'b1, mem[0], 1'b0} : (c == 6) ? {1'b1, mem[2], 1'b0} : 34'h0;
            e2 = (c == 7) ? {1'b1, mem[2], 1'b0} : 34'h0;
            total++;
            if ({act_v[0], act_d[0], act_e[0]} !== e1) begin
                bad++;
                $display("FAIL rstmid_dut1 cyc=%0d got=%h exp=%h", c, {act_v[0], act_d[0], act_e[0]}, e1);
            end
            total++;
            if ({act_v[1], act_d[1], act_e[1]} !== e2) begin
                bad++;
                $display("FAIL rstmid_dut2 cyc=%0d got=%h exp=%h", c, {act_v[1], act_d[1], act_e[1]}, e2);
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic [2:0] legal [5];
        logic [2:0] f;
        legal = '{LB, LH, LW, LBU, LHU};
        for (int n = 0; n < 600; n++) begin
            junk = $urandom;
            f = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70, $urandom, f,
                  $urandom_range(0, 99) < 25);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (act_v[k] !== ev[k] || act_d[k] !== ed[k] || act_e[k] !== ee[k]) begin
                    bad++;
                    $display("FAIL rand_dut%0d cyc=%0d got v=%0b d=%h e=%0b exp v=%0b d=%h e=%0b",
                             k + 1, n, act_v[k], act_d[k], act_e[k], ev[k], ed[k], ee[k]);
                end
            end
            advance();
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_f3 = LW; stall = 1'b0;
        junk = 32'h0;
        md[0] = 32'h0; md[1] = 32'h0;
        for (int k = 0; k < 2; k++) begin
            hold[k] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_vld[k][i]  = 1'b0;
                m_addr[k][i] = 32'h0;
                m_f3[k][i]   = 3'b0;
            end
        end
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        @(negedge clk);
        test_reset();
        test_lb_sign();
        test_half();
        test_err();
        test_stall_hold();
        test_back_to_back();
        test_rst_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
